color_clock_render: RTL and testbench

- Downstream of the VGA sync generator; consumes its h_sync/v_sync/onscreen outputs on the same 25 MHz clock.
- Keeps time of day (hh:mm:ss) and renders three horizontal bar-graph bands (hours, minutes, seconds) as 640x480 RGB.
- Re-times the sync outputs so they stay aligned with the registered RGB outputs going to the DAC/pins.

---
 rtl/color_clock_pkg.sv | 37 +++
 rtl/time_of_day_counter.sv | 80 ++++++++
 rtl/color_clock_render.sv | 123 ++++++++++++
 tb/tb_color_clock_render.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_clock_pkg.sv
// Shared constants and helpers for the colour bar-graph clock.
package color_clock_pkg;

    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] HOURS_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX   = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX   = 6'd59;

    localparam logic [Y_W-1:0] BAND_MIN_Y = 9'd160;
    localparam logic [Y_W-1:0] BAND_SEC_Y = 9'd320;

    localparam logic [X_W-1:0] HOUR_SCALE = 10'd26;
    localparam logic [X_W-1:0] MS_SCALE   = 10'd10;

    typedef enum logic [1:0] {
        BAND_HOURS   = 2'd0,
        BAND_MINUTES = 2'd1,
        BAND_SECONDS = 2'd2
    } band_e;

    // Which horizontal band a line belongs to.
    function automatic band_e band_of(input logic [Y_W-1:0] y);
        if (y < BAND_MIN_Y) begin
            return BAND_HOURS;
        end else if (y < BAND_SEC_Y) begin
            return BAND_MINUTES;
        end else begin
            return BAND_SECONDS;
        end
    endfunction

endpackage

// File: rtl/time_of_day_counter.sv
// Prescaler plus hh:mm:ss counters with a validated time load.
module time_of_day_counter
    import color_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ = 25000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    output logic              sec_tick,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  minutes_q, minutes_d;
    logic [SEC_W-1:0]  seconds_q, seconds_d;
    logic              tick_q, tick_d;
    logic              set_ok;

    // Next time: a valid load beats the terminal count, else count and carry.
    always_comb begin
        presc_d   = presc_q + 1'b1;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        tick_d    = 1'b0;
        set_ok    = set_en && (set_hours <= HOURS_MAX) && (set_minutes <= MIN_MAX);
        if (set_ok) begin
            presc_d   = '0;
            hours_d   = set_hours;
            minutes_d = set_minutes;
            seconds_d = '0;
        end else if (presc_q == PRE_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (seconds_q == SEC_MAX) begin
                seconds_d = '0;
                if (minutes_q == MIN_MAX) begin
                    minutes_d = '0;
                    hours_d   = (hours_q == HOURS_MAX) ? '0 : hours_q + 1'b1;
                end else begin
                    minutes_d = minutes_q + 1'b1;
                end
            end else begin
                seconds_d = seconds_q + 1'b1;
            end
        end
    end

    // Time-of-day state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            tick_q    <= tick_d;
        end
    end

    assign sec_tick = tick_q;
    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;

endmodule

// File: rtl/color_clock_render.sv
// Renders hours/minutes/seconds as three bar-graph bands and re-times sync.
module color_clock_render
    import color_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 25000000,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned COLOR_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic               onscreen_in,
    input  logic               set_en,
    input  logic [HOUR_W-1:0]  set_hours,
    input  logic [MIN_W-1:0]   set_minutes,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic               sec_tick,
    output logic [HOUR_W-1:0]  hours,
    output logic [MIN_W-1:0]   minutes,
    output logic [SEC_W-1:0]   seconds
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);
    localparam logic [COLOR_W-1:0] DIM = COLOR_W'(1);

    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               on_q;
    logic               hs_q, vs_q;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [X_W-1:0]     bar_len;

    time_of_day_counter #(
        .CLK_HZ(CLK_HZ)
    ) u_tod (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (set_en),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .sec_tick    (sec_tick),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds)
    );

    // Pixel and line position, both saturating; vsync clear beats the line step.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!onscreen_in) begin
            x_d = '0;
        end else if (x_q != X_LAST) begin
            x_d = x_q + 1'b1;
        end
        if (!v_sync_in) begin
            y_d = '0;
        end else if (on_q && !onscreen_in && (y_q != Y_LAST)) begin
            y_d = y_q + 1'b1;
        end
    end

    // Band select and bar compare for the pixel currently on the wire.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        bar_len = '0;
        if (onscreen_in) begin
            unique case (band_of(y_q))
                BAND_HOURS: begin
                    bar_len = X_W'(hours) * HOUR_SCALE;
                    red_d   = (x_q < bar_len) ? '1 : DIM;
                end
                BAND_MINUTES: begin
                    bar_len = X_W'(minutes) * MS_SCALE;
                    green_d = (x_q < bar_len) ? '1 : DIM;
                end
                default: begin
                    bar_len = X_W'(seconds) * MS_SCALE;
                    blue_d  = (x_q < bar_len) ? '1 : DIM;
                end
            endcase
        end
    end

    // Position, RGB and one-cycle sync delay registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            on_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            on_q    <= onscreen_in;
            hs_q    <= h_sync_in;
            vs_q    <= v_sync_in;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign h_sync_out = hs_q;
    assign v_sync_out = vs_q;

endmodule

// File: tb/tb_color_clock_render.sv
// Self-checking bench for color_clock_render with a small prescaler.
module tb_color_clock_render;

    localparam int CLK_HZ = 10;

    int checks   = 0;
    int failures = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       h_sync_in = 1'b1;
    logic       v_sync_in = 1'b1;
    logic       onscreen_in = 1'b0;
    logic       set_en = 1'b0;
    logic [4:0] set_hours = '0;
    logic [5:0] set_minutes = '0;
    logic [3:0] red, green, blue;
    logic       h_sync_out, v_sync_out, sec_tick;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;

    color_clock_render #(
        .CLK_HZ   (CLK_HZ),
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .COLOR_W  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .onscreen_in (onscreen_in),
        .set_en      (set_en),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .sec_tick    (sec_tick),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds)
    );

    always #20 clk = ~clk;

    // Reference time: seconds-of-day at the last load plus elapsed clock cycles.
    int m_base = 0;
    int m_cyc  = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_base <= 0;
            m_cyc  <= 0;
        end else if (set_en && int'(set_hours) <= 23 && int'(set_minutes) <= 59) begin
            m_base <= int'(set_hours) * 3600 + int'(set_minutes) * 60;
            m_cyc  <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    function automatic int now_secs();
        return (m_base + m_cyc / CLK_HZ) % 86400;
    endfunction

    // {sec_tick, hours, minutes, seconds} expected right now.
    function automatic logic [17:0] exp_clock();
        int s;
        logic tk;
        s  = now_secs();
        tk = (m_cyc > 0) && (m_cyc % CLK_HZ == 0);
        return {tk, 5'(s / 3600), 6'((s / 60) % 60), 6'(s % 60)};
    endfunction

    // {red, green, blue} one cycle after presenting this pixel.
    function automatic logic [11:0] exp_rgb(input bit on, input int x, input int y);
        int s, h, m, sec;
        s   = now_secs();
        h   = s / 3600;
        m   = (s / 60) % 60;
        sec = s % 60;
        if (!on) return 12'h000;
        if (y < 160) return {((x < h * 26) ? 4'hf : 4'h1), 8'h00};
        if (y < 320) return {4'h0, ((x < m * 10) ? 4'hf : 4'h1), 4'h0};
        return {8'h00, ((x < sec * 10) ? 4'hf : 4'h1)};
    endfunction

    task automatic test_reset();
        h_sync_in   = 1'b0;
        v_sync_in   = 1'b0;
        onscreen_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({red, green, blue, h_sync_out, v_sync_out, sec_tick, hours, minutes, seconds}
            !== {12'h000, 2'b11, 1'b0, 17'h0}) begin
            failures++;
            $display("FAIL reset_state: got %h %h %h hs=%b vs=%b tick=%b %0d:%0d:%0d",
                     red, green, blue, h_sync_out, v_sync_out, sec_tick, hours, minutes, seconds);
        end
        h_sync_in   = 1'b1;
        v_sync_in   = 1'b1;
        onscreen_in = 1'b0;
    endtask

    task automatic test_tick();
        int first = 0;
        rst_n = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            checks++;
            if ({sec_tick, hours, minutes, seconds} !== exp_clock()) begin
                failures++;
                $display("FAIL tick_count cyc=%0d: got %h want %h", i,
                         {sec_tick, hours, minutes, seconds}, exp_clock());
            end
            if (sec_tick && first == 0) begin
                first = i;
                checks++;
                if (seconds !== 6'd1) begin
                    failures++;
                    $display("FAIL first_second: seconds=%0d want 1", seconds);
                end
            end
        end
        checks++;
        if (first !== 10) begin
            failures++;
            $display("FAIL first_tick_cycle: got %0d want 10", first);
        end
    endtask

    task automatic test_wrap();
        int ticks = 0;
        set_hours = 5'd23; set_minutes = 6'd59; set_en = 1'b1;
        @(negedge clk);
        set_en = 1'b0;
        checks++;
        if ({sec_tick, hours, minutes, seconds} !== {1'b0, 5'd23, 6'd59, 6'd0}) begin
            failures++;
            $display("FAIL wrap_load: got %0d:%0d:%0d tick=%b want 23:59:00 tick=0",
                     hours, minutes, seconds, sec_tick);
        end
        for (int i = 1; i <= 60 * CLK_HZ; i++) begin
            @(negedge clk);
            checks++;
            if ({sec_tick, hours, minutes, seconds} !== exp_clock()) begin
                failures++;
                $display("FAIL wrap_run cyc=%0d: got %h want %h", i,
                         {sec_tick, hours, minutes, seconds}, exp_clock());
            end
            if (sec_tick) ticks++;
        end
        checks++;
        if ({sec_tick, hours, minutes, seconds} !== {1'b1, 17'h0}) begin
            failures++;
            $display("FAIL wrap_midnight: got %0d:%0d:%0d tick=%b want 0:0:0 tick=1",
                     hours, minutes, seconds, sec_tick);
        end
        checks++;
        if (ticks !== 60) begin
            failures++;
            $display("FAIL wrap_tick_total: got %0d want 60", ticks);
        end
    endtask

    task automatic test_set();
        int guard = 0;
        logic [10:0] bad [3];
        bad[0] = {5'd24, 6'd5};
        bad[1] = {5'd5, 6'd60};
        bad[2] = {5'd31, 6'd63};
        for (int k = 0; k < 3; k++) begin
            {set_hours, set_minutes} = bad[k];
            set_en = 1'b1;
            @(negedge clk);
            set_en = 1'b0;
            checks++;
            if ({sec_tick, hours, minutes, seconds} !== exp_clock()) begin
                failures++;
                $display("FAIL set_invalid %0d:%0d: got %h want %h", bad[k][10:6], bad[k][5:0],
                         {sec_tick, hours, minutes, seconds}, exp_clock());
            end
        end
        while ((m_cyc % CLK_HZ) != CLK_HZ - 1 && guard < 4 * CLK_HZ) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 4 * CLK_HZ) begin
            failures++;
            $display("FAIL set_align_timeout: waited %0d cycles", guard);
        end
        set_hours = 5'd1; set_minutes = 6'd2; set_en = 1'b1;
        @(negedge clk);
        set_en = 1'b0;
        checks++;
        if ({sec_tick, hours, minutes, seconds} !== {1'b0, 5'd1, 6'd2, 6'd0}) begin
            failures++;
            $display("FAIL set_vs_tick: got %0d:%0d:%0d tick=%b want 1:2:0 tick=0",
                     hours, minutes, seconds, sec_tick);
        end
        for (int k = 0; k < 25; k++) begin
            set_hours   = 5'($urandom_range(0, 31));
            set_minutes = 6'($urandom_range(0, 63));
            set_en      = 1'b1;
            @(negedge clk);
            set_en = 1'b0;
            for (int i = 0; i < int'($urandom_range(1, 25)); i++) begin
                checks++;
                if ({sec_tick, hours, minutes, seconds} !== exp_clock()) begin
                    failures++;
                    $display("FAIL set_random #%0d: got %h want %h", k,
                             {sec_tick, hours, minutes, seconds}, exp_clock());
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_frame(input int h, input int m, input bit do_set, input bit rand_lines);
        logic [11:0] exp;
        int  yl, len, red_full;
        bit  full;
        if (do_set) begin
            set_hours = 5'(h); set_minutes = 6'(m); set_en = 1'b1;
            @(negedge clk);
            set_en = 1'b0;
        end
        onscreen_in = 1'b0;
        v_sync_in   = 1'b0;
        repeat (2) @(negedge clk);
        v_sync_in = 1'b1;
        @(negedge clk);
        for (yl = 0; yl <= 481; yl++) begin
            full = (yl == 0 || yl == 10 || yl == 159 || yl == 160 || yl == 200 ||
                    yl == 319 || yl == 320 || yl == 400 || yl == 479 || yl == 481) ||
                   (rand_lines && $urandom_range(0, 99) == 0);
            len = full ? 645 : int'($urandom_range(1, 3));
            red_full = 0;
            for (int i = 0; i < len; i++) begin
                onscreen_in = 1'b1;
                exp = exp_rgb(1'b1, (i > 639) ? 639 : i, (yl > 479) ? 479 : yl);
                @(negedge clk);
                checks++;
                if ({red, green, blue} !== exp) begin
                    failures++;
                    $display("FAIL frame_pixel y=%0d x=%0d: got %h want %h", yl, i,
                             {red, green, blue}, exp);
                end
                if (yl == 10 && i < 640 && red === 4'hf) red_full++;
            end
            onscreen_in = 1'b0;
            @(negedge clk);
            checks++;
            if ({red, green, blue} !== 12'h000) begin
                failures++;
                $display("FAIL frame_offscreen y=%0d: got %h want 000", yl, {red, green, blue});
            end
            if (yl == 10 && do_set && !rand_lines) begin
                checks++;
                if (red_full !== h * 26) begin
                    failures++;
                    $display("FAIL hours_bar_len: got %0d want %0d", red_full, h * 26);
                end
            end
        end
    endtask

    task automatic test_offscreen_sync();
        logic hs_p, vs_p;
        onscreen_in = 1'b0;
        for (int i = 0; i < 60; i++) begin
            hs_p      = 1'($urandom_range(0, 1));
            vs_p      = 1'($urandom_range(0, 1));
            h_sync_in = hs_p;
            v_sync_in = vs_p;
            @(negedge clk);
            checks++;
            if ({h_sync_out, v_sync_out, red, green, blue} !== {hs_p, vs_p, 12'h000}) begin
                failures++;
                $display("FAIL sync_delay #%0d: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=000",
                         i, h_sync_out, v_sync_out, {red, green, blue}, hs_p, vs_p);
            end
        end
        h_sync_in = 1'b1;
        v_sync_in = 1'b1;
    endtask

    task automatic test_reset_midline();
        set_hours = 5'd20; set_minutes = 6'd45; set_en = 1'b1;
        @(negedge clk);
        set_en = 1'b0;
        h_sync_in = 1'b0;
        onscreen_in = 1'b1;
        repeat (100) @(negedge clk);
        #7;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({red, green, blue, h_sync_out, v_sync_out, sec_tick, hours, minutes, seconds}
            !== {12'h000, 2'b11, 1'b0, 17'h0}) begin
            failures++;
            $display("FAIL reset_async: got %h %h %h hs=%b vs=%b tick=%b %0d:%0d:%0d",
                     red, green, blue, h_sync_out, v_sync_out, sec_tick, hours, minutes, seconds);
        end
        onscreen_in = 1'b0;
        h_sync_in   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_frame(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tick();
        test_wrap();
        test_set();
        test_frame(12, 30, 1'b1, 1'b0);
        test_offscreen_sync();
        test_frame(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), 1'b1, 1'b1);
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
